pp_uart_tx_fifo: RTL and testbench
==================================

Name: pp_uart_tx_fifo

Overview:
Parametrised second-generation UART transmitter for the RISC-V core peripheral set. It buffers outgoing characters in an internal FIFO and serialises them at a configurable oversampling ratio. Frame formats are 5–8 data bits with none/odd/even/mark/space parity and 1 or 2 stop bits. It adds break generation, back-to-back framing, a transmit-enable gate and FIFO status to the bus wrapper.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit cell (range 4–64)
FIFO_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
soft_rst  in  1  synchronous reset, active-low; same effect as rst
baud_tick  in  1  one-clk pulse at OVERSAMPLE × baud
wr_valid  in  1  push request
wr_data  in  8  character to push
wr_ready  out  1  FIFO can accept (level < FIFO_DEPTH)
tx_en  in  1  allows new frames to start
cfg_len  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space, others = none
cfg_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits
cfg_break  in  1  force break (line low)
uart_tx  out  1  serial line, registered
tx_busy  out  1  state != IDLE
tx_done  out  1  one-clk pulse at the end of each frame's last stop bit
fifo_level  out  LVL_W  current entries
fifo_empty  out  1  level == 0

Behaviour:
- Reset (rst or soft_rst): FIFO flushed, level=0, wr_ready=1, fifo_empty=1, uart_tx=1, tx_busy=0, tx_done=0, state IDLE, counters 0. soft_rst mid-frame aborts the frame; the line returns high on the next clk.
- FIFO: push on wr_valid && wr_ready. Pop is internal, at frame start. Push and pop in the same clk leave the level unchanged. A push while full is ignored (wr_ready=0). Pointers wrap modulo FIFO_DEPTH.
- Config (len/parity/stop) is latched at frame start. Changes mid-frame have no effect on that frame.
- Tick counter: counts baud_ticks 0..OVERSAMPLE-1 within each bit cell. The bit cell ends on the baud_tick with count == OVERSAMPLE-1, and the counter then clears. Every bit lasts exactly OVERSAMPLE ticks.
- States:
  - IDLE: uart_tx=1. On baud_tick:
    - if cfg_break=1 → BREAK (takes priority over data);
    - else if tx_en && !fifo_empty → pop, load the shift register, latch config, → START.
  - START: uart_tx=0 for 1 bit cell → DATA.
  - DATA: uart_tx = shift[0], LSB first. Shift at each cell end; after len cells → PARITY if parity != none, else STOP.
  - PARITY: 1 cell. odd = ~^data[len-1:0], even = ^data[len-1:0], mark = 1, space = 0 → STOP.
  - STOP: uart_tx=1 for 1 or 2 cells. At the last cell end, pulse tx_done → IDLE.
  - BREAK: uart_tx=0 while cfg_break=1. Once cfg_break=0 is seen at a cell end → MARK.
  - MARK: uart_tx=1 for 1 cell → IDLE. Break never corrupts an in-flight frame; it is sampled only in IDLE.
- Latency: uart_tx changes on the clk after the deciding baud_tick. The START falling edge occurs 1 clk after the start baud_tick.
- Back-to-back: with FIFO non-empty and tx_en=1, the next START begins on the baud_tick after the tx_done tick. The gap is therefore 1 baud_tick of idle-high.
- Frame length in ticks = OVERSAMPLE × (1 + len + P + S), where P = 0 or 1 (parity) and S = 1 or 2 (stop bits).
- tx_en=0 mid-frame: the current frame completes and no new frame starts.
- A default state branch returns to IDLE with uart_tx=1.

Test Plan:
- OVERSAMPLE=16, 8N1, push 0x55, tx_en=1 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each for 16 ticks. tx_done fires at tick 160 after start; fifo_empty=1 after the pop.
- 7O1, push 0x41 → start, 1,0,0,0,0,0,1, parity=1, stop. 5E2, push 0xFF → start, 1,1,1,1,1, parity=1, two stop cells (9 cells total = 144 ticks).
- Mark/space: 8M1 0x00 → parity cell=1; 8S1 0xFF → parity cell=0.
- tx_en=0, push 9 bytes (DEPTH=8) → wr_ready drops after the 8th, level=8, 9th byte dropped. Then tx_en=1 → 8 frames with exactly a 1-tick inter-frame gap, 8 tx_done pulses, level decrements by 1 per frame start.
- Simultaneous push and pop at level=3 → level stays 3. Config changed mid-frame → current frame unaffected, next frame uses the new config.
- cfg_break=1 during a frame → frame completes, then line low. Deassert → ≥1 cell high, then the queued byte transmits. soft_rst mid-DATA → uart_tx=1 next clk, level=0, tx_busy=0.

Source files
------------

// File: rtl/pp_uart_tx_fifo.sv
// pp_uart_tx_fifo: FIFO-buffered UART transmitter with 5-8 data bits, parity, 1/2 stop bits and break
// Ports:
//   clk, rst (async, active-low), soft_rst (sync, active-low)
//   baud_tick             one-clk pulse at OVERSAMPLE x baud
//   wr_valid/wr_data/wr_ready   character push interface
//   tx_en                 gates the start of new frames
//   cfg_len/cfg_parity/cfg_stop  frame format, latched at frame start
//   cfg_break             hold the line low (sampled only while idle)
//   uart_tx               registered serial line
//   tx_busy, tx_done      transmitter activity and end-of-frame pulse
//   fifo_level, fifo_empty  FIFO status
module pp_uart_tx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             baud_tick,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             tx_en,
  input  logic [1:0]       cfg_len,
  input  logic [2:0]       cfg_parity,
  input  logic             cfg_stop,
  input  logic             cfg_break,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MARK} stateT;
  stateT state, stateNext;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [TW-1:0] tickCnt;
  logic [2:0] bitCnt;
  logic stopCnt, stopR, parEn, parBit;
  logic [1:0] lenR;
  logic [7:0] shiftReg, shiftNext, popData;
  logic push, pop, cellEnd, lastBit, txNext, doneNext, rawPar;
  assign wr_ready = fifo_level < LVL_W'(FIFO_DEPTH);
  assign fifo_empty = fifo_level == '0;
  assign tx_busy = state != IDLE;
  assign push = wr_valid && wr_ready;
  assign pop = state == IDLE && baud_tick && !cfg_break && tx_en && !fifo_empty;
  assign cellEnd = baud_tick && tickCnt == TW'(OVERSAMPLE - 1);
  assign lastBit = bitCnt == {1'b0, lenR} + 3'd4;
  assign popData = mem[rdPtr];
  // even parity of the low cfg_len+5 bits of the character being popped
  assign rawPar = ^(popData & (8'hff >> (2'd3 - cfg_len)));
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= wr_data;
  always_comb begin
    stateNext = state;
    doneNext = 1'b0;
    case (state)
      IDLE:   stateNext = !baud_tick ? IDLE : cfg_break ? BRK : pop ? START : IDLE;
      START:  stateNext = cellEnd ? DATA : START;
      DATA:   stateNext = !(cellEnd && lastBit) ? DATA : parEn ? PARITY : STOP;
      PARITY: stateNext = cellEnd ? STOP : PARITY;
      STOP: begin
        doneNext = cellEnd && stopCnt == stopR;
        stateNext = doneNext ? IDLE : STOP;
      end
      BRK:    stateNext = (cellEnd && !cfg_break) ? MARK : BRK;
      MARK:   stateNext = cellEnd ? IDLE : MARK;
      default: stateNext = IDLE;
    endcase
    shiftNext = pop ? popData : (state == DATA && cellEnd) ? {1'b0, shiftReg[7:1]} : shiftReg;
    // the line is registered from the next state so it moves one clk after the deciding tick
    txNext = (stateNext == START || stateNext == BRK) ? 1'b0 :
             stateNext == DATA ? shiftNext[0] :
             stateNext == PARITY ? parBit : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
      shiftReg <= '0;
      tickCnt <= '0;
      bitCnt <= '0;
      stopCnt <= 1'b0;
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_level <= '0;
      lenR <= '0;
      stopR <= 1'b0;
      parEn <= 1'b0;
      parBit <= 1'b0;
    end else if (!soft_rst) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
      shiftReg <= '0;
      tickCnt <= '0;
      bitCnt <= '0;
      stopCnt <= 1'b0;
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_level <= '0;
      lenR <= '0;
      stopR <= 1'b0;
      parEn <= 1'b0;
      parBit <= 1'b0;
    end else begin
      state <= stateNext;
      uart_tx <= txNext;
      tx_done <= doneNext;
      shiftReg <= shiftNext;
      tickCnt <= (state == IDLE || cellEnd) ? '0 : baud_tick ? tickCnt + TW'(1) : tickCnt;
      bitCnt <= pop ? '0 : (state == DATA && cellEnd) ? bitCnt + 3'd1 : bitCnt;
      stopCnt <= pop ? 1'b0 : (state == STOP && cellEnd) ? 1'b1 : stopCnt;
      wrPtr <= push ? wrPtr + AW'(1) : wrPtr;
      rdPtr <= pop ? rdPtr + AW'(1) : rdPtr;
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
      if (pop) begin
        lenR <= cfg_len;
        stopR <= cfg_stop;
        parEn <= cfg_parity != 3'd0 && cfg_parity <= 3'd4;
        parBit <= cfg_parity == 3'd1 ? ~rawPar : cfg_parity == 3'd2 ? rawPar : cfg_parity == 3'd3;
      end
    end
endmodule

// File: tb/tb_pp_uart_tx_fifo.sv
// tb_pp_uart_tx_fifo: randomized self-checking bench for pp_uart_tx_fifo against a tick-level line model
module tb_pp_uart_tx_fifo;
  localparam int OS = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst, soft_rst, autoTick, manTick, tickEn, wr_valid, tx_en, cfg_stop, cfg_break;
  logic baud_tick;
  logic [7:0] wr_data;
  logic [1:0] cfg_len;
  logic [2:0] cfg_parity;
  logic wr_ready, uart_tx, tx_busy, tx_done, fifo_empty;
  logic [3:0] fifo_level;
  logic [7:0] fifoQ[$];
  bit lineQ[$];
  bit expLine = 1'b1, expDone = 1'b0, busyM = 1'b0, brkM = 1'b0, doneOnEnd = 1'b0, checking = 1'b0;
  int brkCnt = 0, tickTotal = 0, nChecks = 0, nFails = 0;

  pp_uart_tx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .baud_tick(baud_tick),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .tx_en(tx_en),
    .cfg_len(cfg_len), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .cfg_break(cfg_break),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty)
  );

  assign baud_tick = autoTick | manTick;
  always #5 clk = ~clk;
  always @(negedge clk) autoTick = tickEn && ($urandom_range(0, 2) == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: got %0h, want %0h @%0t", tag, got, want, $time);
    end
  endtask

  // whole frame as a list of cells, each expanded to OS line samples
  task automatic buildFrame(input logic [7:0] d);
    bit c[$];
    int n, ones;
    n = int'(cfg_len) + 5;
    ones = 0;
    c.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      c.push_back(d[i]);
      ones += int'(d[i]);
    end
    case (cfg_parity)
      3'd1: c.push_back(ones % 2 == 0);
      3'd2: c.push_back(ones % 2 == 1);
      3'd3: c.push_back(1'b1);
      3'd4: c.push_back(1'b0);
      default: ;
    endcase
    c.push_back(1'b1);
    if (cfg_stop) c.push_back(1'b1);
    foreach (c[k]) repeat (OS) lineQ.push_back(c[k]);
  endtask

  always @(posedge clk) begin : model
    int lvl;
    if (baud_tick) tickTotal++;
    lvl = fifoQ.size();
    if (!rst || !soft_rst) begin
      fifoQ.delete();
      lineQ.delete();
      expLine = 1'b1;
      expDone = 1'b0;
      busyM = 1'b0;
      brkM = 1'b0;
    end else begin
      expDone = 1'b0;
      if (baud_tick) begin
        if (brkM) begin
          brkCnt++;
          if (brkCnt == OS) begin
            brkCnt = 0;
            if (!cfg_break) begin
              brkM = 1'b0;
              busyM = 1'b1;
              doneOnEnd = 1'b0;
              expLine = 1'b1;
              repeat (OS - 1) lineQ.push_back(1'b1);
            end
          end
        end else if (busyM) begin
          if (lineQ.size() > 0) expLine = lineQ.pop_front();
          else begin
            expLine = 1'b1;
            expDone = doneOnEnd;
            busyM = 1'b0;
          end
        end else if (cfg_break) begin
          brkM = 1'b1;
          brkCnt = 0;
          expLine = 1'b0;
        end else if (tx_en && lvl > 0) begin
          buildFrame(fifoQ.pop_front());
          expLine = lineQ.pop_front();
          busyM = 1'b1;
          doneOnEnd = 1'b1;
        end
      end
      if (wr_valid && lvl < DEPTH) fifoQ.push_back(wr_data);
    end
  end

  always @(negedge clk)
    if (checking) begin
      check("uart_tx", 32'(uart_tx), 32'(expLine));
      check("tx_done", 32'(tx_done), 32'(expDone));
      check("tx_busy", 32'(tx_busy), 32'(busyM || brkM));
      check("fifo_level", 32'(fifo_level), 32'(fifoQ.size()));
      check("wr_ready", 32'(wr_ready), 32'(fifoQ.size() < DEPTH));
      check("fifo_empty", 32'(fifo_empty), 32'(fifoQ.size() == 0));
    end

  task automatic setCfg(input logic [1:0] l, input logic [2:0] p, input logic s);
    cfg_len = l;
    cfg_parity = p;
    cfg_stop = s;
  endtask

  task automatic pushByte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    int t0;
    t0 = tickTotal;
    for (int c = 0; c < n * 20 && tickTotal - t0 < n; c++) @(negedge clk);
  endtask

  task automatic waitIdle(input string tag, input int bound);
    for (int c = 0; c < bound && (tx_busy || !fifo_empty); c++) @(negedge clk);
    check(tag, 32'(tx_busy || !fifo_empty), 32'd0);
  endtask

  // ticks from enabling tx_en up to and including the tx_done tick: start tick + cells*OS
  task automatic timeFrame(input string tag, input logic [7:0] d, input int want);
    int t0;
    tx_en = 1'b0;
    pushByte(d);
    tx_en = 1'b1;
    t0 = tickTotal;
    for (int c = 0; c < 10000 && !tx_done; c++) @(negedge clk);
    check(tag, 32'(tickTotal - t0), 32'(want));
  endtask

  initial begin
    int nDone;
    rst = 1'b0; soft_rst = 1'b1; tickEn = 1'b0; autoTick = 1'b0; manTick = 1'b0;
    wr_valid = 1'b0; wr_data = '0; tx_en = 1'b0; cfg_break = 1'b0;
    setCfg(2'd3, 3'd0, 1'b0);
    checking = 1'b1;
    repeat (3) @(negedge clk);
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset wr_ready", 32'(wr_ready), 32'd1);
    check("reset fifo_empty", 32'(fifo_empty), 32'd1);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset busy", 32'(tx_busy), 32'd0);
    rst = 1'b1;
    tickEn = 1'b1;
    @(negedge clk);
    timeFrame("8N1 0x55 ticks", 8'h55, OS * 10 + 1);
    check("8N1 empty after", 32'(fifo_empty), 32'd1);
    setCfg(2'd2, 3'd1, 1'b0);
    timeFrame("7O1 0x41 ticks", 8'h41, OS * 10 + 1);
    setCfg(2'd0, 3'd2, 1'b1);
    timeFrame("5E2 0xFF ticks", 8'hff, OS * 9 + 1);
    setCfg(2'd3, 3'd3, 1'b0);
    timeFrame("8M1 0x00 ticks", 8'h00, OS * 11 + 1);
    setCfg(2'd3, 3'd4, 1'b0);
    timeFrame("8S1 0xFF ticks", 8'hff, OS * 11 + 1);
    setCfg(2'd3, 3'd0, 1'b0);
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) pushByte(8'(i * 37 + 1));
    check("full level", 32'(fifo_level), 32'd8);
    check("full wr_ready", 32'(wr_ready), 32'd0);
    tx_en = 1'b1;
    nDone = 0;
    for (int c = 0; c < 20000 && (tx_busy || !fifo_empty); c++) begin
      @(negedge clk);
      if (tx_done) nDone++;
    end
    check("burst tx_done count", 32'(nDone), 32'd8);
    tickEn = 1'b0;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    pushByte(8'h12); pushByte(8'h34); pushByte(8'h56);
    tx_en = 1'b1; manTick = 1'b1; wr_valid = 1'b1; wr_data = 8'h5a;
    @(negedge clk);
    manTick = 1'b0; wr_valid = 1'b0;
    check("push+pop level", 32'(fifo_level), 32'd3);
    tickEn = 1'b1;
    waitTicks(50);
    setCfg(2'd1, 3'd2, 1'b1);
    waitIdle("cfg change drain", 40000);
    setCfg(2'd3, 3'd0, 1'b0);
    tx_en = 1'b0;
    pushByte(8'ha5); pushByte(8'h3c);
    tx_en = 1'b1;
    waitTicks(30);
    cfg_break = 1'b1;
    waitTicks(170);
    check("break line", 32'(uart_tx), 32'd0);
    check("break level", 32'(fifo_level), 32'd1);
    check("break busy", 32'(tx_busy), 32'd1);
    cfg_break = 1'b0;
    waitIdle("break drain", 20000);
    tx_en = 1'b0;
    pushByte(8'h00); pushByte(8'h11); pushByte(8'h22);
    tx_en = 1'b1;
    waitTicks(40);
    check("srst pre line", 32'(uart_tx), 32'd0);
    soft_rst = 1'b0;
    @(negedge clk);
    check("srst line", 32'(uart_tx), 32'd1);
    check("srst level", 32'(fifo_level), 32'd0);
    check("srst busy", 32'(tx_busy), 32'd0);
    soft_rst = 1'b1;
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 11) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 199) == 0) setCfg(2'($urandom), 3'($urandom), 1'($urandom));
      if ($urandom_range(0, 399) == 0) tx_en = ~tx_en;
      if (!cfg_break && $urandom_range(0, 2999) == 0) cfg_break = 1'b1;
      else if (cfg_break && $urandom_range(0, 149) == 0) cfg_break = 1'b0;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    cfg_break = 1'b0;
    tx_en = 1'b1;
    waitIdle("final drain", 60000);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
